// File: rtl/modport_alu.sv
// modport_alu: registered ALU with arithmetic and logical command sets.
// It waits up to 16 enabled cycles for missing operands, and it uses a
// two-cycle path for the multiply commands.
module modport_alu #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [1:0]           inp_valid,
    input  logic                 ce,
    input  logic                 cin,
    input  logic                 mode,
    output logic [WIDTH+1:0]     res,
    output logic                 err,
    output logic                 oflow,
    output logic                 cout,
    output logic                 g,
    output logic                 l,
    output logic                 e
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW  = 2 * WIDTH + 2;
    localparam logic [3:0] TIMEOUT_LAST = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL1} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     lat_a, lat_b;
    logic [CMD_WIDTH-1:0] lat_cmd;
    logic                 lat_mode, lat_cin;
    logic                 got_a, got_b;
    logic [3:0]           cnt;

    logic [CMD_WIDTH-1:0] sel_cmd;
    logic                 sel_mode, sel_cin;
    logic [31:0]          cmd_n;
    logic [WIDTH-1:0]     eff_a, eff_b;
    logic                 have_a, have_b, need_a, need_b;
    logic                 cmd_bad, is_mul, complete;
    logic                 do_result, do_error;

    logic [WIDTH+1:0]     alu_res;
    logic                 alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
    logic [WIDTH:0]       ext_a, ext_b, sx_a, sx_b, sum_w;
    logic [WIDTH-1:0]     log_w;
    logic [2*WIDTH-1:0]   rot_w;
    logic [PW-1:0]        mul_x, mul_y, prod;
    logic [SHW-1:0]       rot_amt;
    logic                 rot_bad;

    // The command comes from the ports in IDLE and from the latched copy
    // afterwards. A newly valid operand overrides the latched one, except
    // in MUL1, where only the latched operands are used.
    always_comb begin
        sel_cmd  = (state == S_IDLE) ? cmd  : lat_cmd;
        sel_mode = (state == S_IDLE) ? mode : lat_mode;
        sel_cin  = (state == S_IDLE) ? cin  : lat_cin;
        cmd_n    = 32'(sel_cmd);
        eff_a    = (state != S_MUL1 && inp_valid[0]) ? opa : lat_a;
        eff_b    = (state != S_MUL1 && inp_valid[1]) ? opb : lat_b;
        have_a   = inp_valid[0] | ((state == S_WAIT) & got_a);
        have_b   = inp_valid[1] | ((state == S_WAIT) & got_b);
        cmd_bad  = sel_mode ? (cmd_n > 32'd12) : (cmd_n > 32'd13);
        is_mul   = sel_mode && (cmd_n == 32'd9 || cmd_n == 32'd10);
    end

    // Work out which operands the selected command actually consumes.
    always_comb begin
        need_a = 1'b1;
        need_b = 1'b1;
        if (sel_mode) begin
            case (cmd_n)
                4, 5:    need_b = 1'b0;
                6, 7:    need_a = 1'b0;
                default: ;
            endcase
        end else begin
            case (cmd_n)
                6, 8, 9:   need_b = 1'b0;
                7, 10, 11: need_a = 1'b0;
                default:   ;
            endcase
        end
        complete = (~need_a | have_a) & (~need_b | have_b);
    end

    // Combinational ALU. Every flag defaults to 0, so each result clears
    // any flag that the operation does not produce.
    always_comb begin
        alu_res   = '0;
        alu_err   = 1'b0;
        alu_oflow = 1'b0;
        alu_cout  = 1'b0;
        alu_g     = 1'b0;
        alu_l     = 1'b0;
        alu_e     = 1'b0;
        sum_w     = '0;
        log_w     = '0;
        rot_w     = '0;
        mul_x     = '0;
        mul_y     = '0;
        prod      = '0;
        ext_a     = {1'b0, eff_a};
        ext_b     = {1'b0, eff_b};
        sx_a      = {eff_a[WIDTH-1], eff_a};
        sx_b      = {eff_b[WIDTH-1], eff_b};
        rot_amt   = eff_b[SHW-1:0];
        rot_bad   = (eff_b >> SHW) != '0;
        if (cmd_bad) begin
            alu_err = 1'b1;
        end else if (sel_mode) begin
            case (cmd_n)
                0: begin sum_w = ext_a + ext_b; alu_cout = sum_w[WIDTH]; end
                1: begin sum_w = ext_a - ext_b; alu_oflow = sum_w[WIDTH]; end
                2: begin
                    sum_w = ext_a + ext_b + (WIDTH+1)'(sel_cin);
                    alu_cout = sum_w[WIDTH];
                end
                3: begin
                    sum_w = ext_a - ext_b - (WIDTH+1)'(sel_cin);
                    alu_oflow = sum_w[WIDTH];
                end
                4: begin sum_w = ext_a + (WIDTH+1)'(1); alu_cout = sum_w[WIDTH]; end
                5: begin sum_w = ext_a - (WIDTH+1)'(1); alu_oflow = sum_w[WIDTH]; end
                6: begin sum_w = ext_b + (WIDTH+1)'(1); alu_cout = sum_w[WIDTH]; end
                7: begin sum_w = ext_b - (WIDTH+1)'(1); alu_oflow = sum_w[WIDTH]; end
                8: begin
                    alu_g = eff_a > eff_b;
                    alu_l = eff_a < eff_b;
                    alu_e = eff_a == eff_b;
                end
                9: begin
                    mul_x = PW'(eff_a) + PW'(1);
                    mul_y = PW'(eff_b) + PW'(1);
                    prod  = mul_x * mul_y;
                end
                10: begin
                    mul_x = PW'({eff_a, 1'b0});
                    mul_y = PW'(eff_b);
                    prod  = mul_x * mul_y;
                end
                11: begin
                    sum_w = sx_a + sx_b;
                    alu_oflow = (eff_a[WIDTH-1] == eff_b[WIDTH-1]) &&
                                (sum_w[WIDTH-1] != eff_a[WIDTH-1]);
                end
                12: begin
                    sum_w = sx_a - sx_b;
                    alu_oflow = (eff_a[WIDTH-1] != eff_b[WIDTH-1]) &&
                                (sum_w[WIDTH-1] != eff_a[WIDTH-1]);
                end
                default: ;
            endcase
            if (cmd_n == 32'd11 || cmd_n == 32'd12) begin
                alu_g   = $signed(eff_a) > $signed(eff_b);
                alu_l   = $signed(eff_a) < $signed(eff_b);
                alu_e   = eff_a == eff_b;
                alu_res = {sum_w[WIDTH], sum_w};
            end else if (is_mul) begin
                alu_res = prod[WIDTH+1:0];
            end else if (cmd_n != 32'd8) begin
                alu_res = {1'b0, sum_w};
            end
        end else begin
            case (cmd_n)
                0:  log_w = eff_a & eff_b;
                1:  log_w = ~(eff_a & eff_b);
                2:  log_w = eff_a | eff_b;
                3:  log_w = ~(eff_a | eff_b);
                4:  log_w = eff_a ^ eff_b;
                5:  log_w = ~(eff_a ^ eff_b);
                6:  log_w = ~eff_a;
                7:  log_w = ~eff_b;
                8:  log_w = eff_a >> 1;
                9:  log_w = eff_a << 1;
                10: log_w = eff_b >> 1;
                11: log_w = eff_b << 1;
                12: begin
                    if (rot_bad) begin
                        alu_err = 1'b1;
                    end else begin
                        rot_w = {eff_a, eff_a} << rot_amt;
                        log_w = rot_w[2*WIDTH-1:WIDTH];
                    end
                end
                13: begin
                    if (rot_bad) begin
                        alu_err = 1'b1;
                    end else begin
                        rot_w = {eff_a, eff_a} >> rot_amt;
                        log_w = rot_w[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
            alu_res = {2'b00, log_w};
        end
    end

    // Next-state logic and the decision whether this enabled cycle
    // publishes a computed result or a plain error.
    always_comb begin
        state_next = state;
        do_result  = 1'b0;
        do_error   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_bad) begin
                    do_result = 1'b1;
                end else if (inp_valid == 2'b00) begin
                    do_error = 1'b1;
                end else if (complete) begin
                    if (is_mul) begin
                        state_next = S_MUL1;
                    end else begin
                        do_result = 1'b1;
                    end
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (complete) begin
                    do_result  = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    do_error   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_MUL1: begin
                do_result  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register, operand and command latches, and the wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            got_a    <= 1'b0;
            got_b    <= 1'b0;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_cmd  <= '0;
            lat_mode <= 1'b0;
            lat_cin  <= 1'b0;
        end else if (ce) begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    lat_cmd  <= cmd;
                    lat_mode <= mode;
                    lat_cin  <= cin;
                    got_a    <= inp_valid[0];
                    got_b    <= inp_valid[1];
                    cnt      <= '0;
                    if (inp_valid[0]) lat_a <= opa;
                    if (inp_valid[1]) lat_b <= opb;
                end
                S_WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (inp_valid[0]) begin
                        lat_a <= opa;
                        got_a <= 1'b1;
                    end
                    if (inp_valid[1]) begin
                        lat_b <= opb;
                        got_b <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output registers. They change only when a result or an error is published.
    always_ff @(posedge clk) begin
        if (rst) begin
            res   <= '0;
            err   <= 1'b0;
            oflow <= 1'b0;
            cout  <= 1'b0;
            g     <= 1'b0;
            l     <= 1'b0;
            e     <= 1'b0;
        end else if (ce) begin
            if (do_result) begin
                res   <= alu_res;
                err   <= alu_err;
                oflow <= alu_oflow;
                cout  <= alu_cout;
                g     <= alu_g;
                l     <= alu_l;
                e     <= alu_e;
            end else if (do_error) begin
                res   <= '0;
                err   <= 1'b1;
                oflow <= 1'b0;
                cout  <= 1'b0;
                g     <= 1'b0;
                l     <= 1'b0;
                e     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modport_alu.sv
// Scoreboard bench for modport_alu. The driver queues hand-computed
// expectations, each tagged with the cycle where it must be visible.
// The monitor pops and compares these expectations on the falling edge.
module tb_modport_alu;

    logic       clk = 1'b0;
    logic       rst, ce, cin, mode;
    logic [7:0] opa, opb;
    logic [3:0] cmd;
    logic [1:0] inp_valid;
    logic [9:0] res;
    logic       err, oflow, cout, g, l, e;

    typedef struct {
        int         due;
        logic [9:0] res;
        logic [5:0] flags;
        string      name;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [9:0] last_res = '0;
    logic [5:0] last_flags = '0;

    // flag order: {err, oflow, cout, g, l, e}
    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_ERR  = 6'b100000;
    localparam logic [5:0] F_OFL  = 6'b010000;
    localparam logic [5:0] F_COUT = 6'b001000;
    localparam logic [5:0] F_G    = 6'b000100;
    localparam logic [5:0] F_L    = 6'b000010;
    localparam logic [5:0] F_E    = 6'b000001;

    modport_alu #(.WIDTH(8), .CMD_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .opa(opa), .opb(opb), .cmd(cmd),
        .inp_valid(inp_valid), .ce(ce), .cin(cin), .mode(mode),
        .res(res), .err(err), .oflow(oflow), .cout(cout),
        .g(g), .l(l), .e(e)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic r, input logic c, input logic m,
                                 input logic [3:0] cm, input logic [7:0] a,
                                 input logic [7:0] b, input logic [1:0] v,
                                 input logic ci);
        @(negedge clk);
        rst = r; ce = c; mode = m; cmd = cm;
        opa = a; opb = b; inp_valid = v; cin = ci;
    endtask

    task automatic op(input logic m, input logic [3:0] cm, input logic [7:0] a,
                      input logic [7:0] b, input logic [1:0] v, input logic ci);
        applyStimulus(1'b0, 1'b1, m, cm, a, b, v, ci);
    endtask

    task automatic idle(input logic c);
        applyStimulus(1'b0, c, 1'b0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic expectResult(input int lat, input logic [9:0] r,
                                input logic [5:0] f, input string nm);
        exp_t x;
        x.due = cyc + lat; x.res = r; x.flags = f; x.name = nm;
        sb_q.push_back(x);
        last_res = r;
        last_flags = f;
    endtask

    task automatic expectHold(input int lat, input string nm);
        exp_t x;
        x.due = cyc + lat; x.res = last_res; x.flags = last_flags; x.name = nm;
        sb_q.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        logic [5:0] act;
        act = {err, oflow, cout, g, l, e};
        total++;
        if (x.due != cyc || res !== x.res || act !== x.flags) begin
            bad++;
            $display("[TB] FAIL %s: got res=%h flags=%b at cycle %0d, want res=%h flags=%b at cycle %0d",
                     x.name, res, act, cyc, x.res, x.flags, x.due);
        end
    endtask

    // Monitor: compares every expectation that has come due.
    always @(negedge clk) begin : monitor
        exp_t x;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            x = sb_q.pop_front();
            checkOutput(x);
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        rst = 1'b1; ce = 1'b0; mode = 1'b0; cmd = '0;
        opa = '0; opb = '0; inp_valid = '0; cin = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0);
        expectResult(1, 10'h000, F_NONE, "reset");

        // arithmetic, latency 1
        op(1, 0, 8'hFF, 8'h01, 2'b11, 0); expectResult(1, 10'h100, F_COUT, "add carry");
        op(1, 2, 8'h10, 8'h20, 2'b11, 1); expectResult(1, 10'h031, F_NONE, "add cin");
        op(1, 1, 8'h03, 8'h05, 2'b11, 0); expectResult(1, 10'h1FE, F_OFL, "sub borrow");
        op(1, 3, 8'h09, 8'h04, 2'b11, 1); expectResult(1, 10'h004, F_NONE, "sub cin");
        op(1, 5, 8'h00, 8'h00, 2'b01, 0); expectResult(1, 10'h1FF, F_OFL, "dec a zero");
        op(1, 6, 8'h00, 8'hFF, 2'b10, 0); expectResult(1, 10'h100, F_COUT, "inc b ff");
        op(1, 8, 8'h05, 8'h09, 2'b11, 0); expectResult(1, 10'h000, F_L, "cmp lt");
        op(1, 8, 8'h07, 8'h07, 2'b11, 0); expectResult(1, 10'h000, F_E, "cmp eq");
        op(1, 8, 8'h09, 8'h05, 2'b11, 0); expectResult(1, 10'h000, F_G, "cmp gt");
        op(1, 11, 8'h7F, 8'h01, 2'b11, 0); expectResult(1, 10'h080, F_OFL | F_G, "sadd ovf");
        op(1, 12, 8'h80, 8'h01, 2'b11, 0); expectResult(1, 10'h37F, F_OFL | F_L, "ssub ovf");
        op(1, 11, 8'hF0, 8'h05, 2'b11, 0); expectResult(1, 10'h3F5, F_L, "sadd neg");

        // multiply, latency 2, outputs hold in between
        op(1, 9, 8'h03, 8'h04, 2'b11, 0);
        expectHold(1, "mul hold");
        expectResult(2, 10'd20, F_NONE, "mul inc");
        idle(1);
        op(1, 10, 8'h03, 8'h05, 2'b11, 0);
        expectHold(1, "mul2 hold");
        expectResult(2, 10'd30, F_NONE, "mul shift");
        idle(1);
        op(1, 9, 8'hFF, 8'hFF, 2'b11, 0);
        expectHold(1, "mul3 hold");
        expectResult(2, 10'h000, F_NONE, "mul trunc");
        idle(1);

        // logical
        op(0, 0, 8'hF0, 8'h3C, 2'b11, 0); expectResult(1, 10'h030, F_NONE, "and");
        op(0, 1, 8'hF0, 8'h3C, 2'b11, 0); expectResult(1, 10'h0CF, F_NONE, "nand");
        op(0, 4, 8'hA5, 8'hFF, 2'b11, 0); expectResult(1, 10'h05A, F_NONE, "xor");
        op(0, 3, 8'h0F, 8'hF0, 2'b11, 0); expectResult(1, 10'h000, F_NONE, "nor");
        op(0, 6, 8'h55, 8'h00, 2'b01, 0); expectResult(1, 10'h0AA, F_NONE, "not a");
        op(0, 9, 8'h81, 8'h00, 2'b01, 0); expectResult(1, 10'h002, F_NONE, "shl a");
        op(0, 10, 8'h00, 8'h81, 2'b10, 0); expectResult(1, 10'h040, F_NONE, "shr b");
        op(0, 12, 8'h81, 8'h01, 2'b11, 0); expectResult(1, 10'h003, F_NONE, "rol 1");
        op(0, 13, 8'h81, 8'h01, 2'b11, 0); expectResult(1, 10'h0C0, F_NONE, "ror 1");
        op(0, 12, 8'h81, 8'h07, 2'b11, 0); expectResult(1, 10'h0C0, F_NONE, "rol 7");
        op(0, 12, 8'h81, 8'h10, 2'b11, 0); expectResult(1, 10'h000, F_ERR, "rot bad amt");
        op(0, 14, 8'h12, 8'h34, 2'b11, 0); expectResult(1, 10'h000, F_ERR, "bad cmd log");
        op(1, 13, 8'h12, 8'h34, 2'b11, 0); expectResult(1, 10'h000, F_ERR, "bad cmd arith");
        op(1, 0, 8'h12, 8'h34, 2'b00, 0); expectResult(1, 10'h000, F_ERR, "no operands");

        // clock enable hold
        op(0, 0, 8'hFF, 8'h0F, 2'b11, 0); expectResult(1, 10'h00F, F_NONE, "and pre hold");
        for (int i = 0; i < 3; i++) begin
            idle(0);
            expectHold(1, "ce hold");
        end

        // timeout after 16 enabled wait cycles
        op(1, 0, 8'h01, 8'h00, 2'b01, 0);
        expectHold(1, "wait hold");
        expectHold(16, "wait pre timeout");
        expectResult(17, 10'h000, F_ERR, "timeout");
        repeat (16) op(1, 0, 8'h01, 8'h00, 2'b01, 0);

        // completion on the fifth wait cycle
        op(1, 0, 8'h20, 8'h00, 2'b01, 0);
        expectHold(1, "wait2 hold");
        expectResult(6, 10'h033, F_NONE, "late complete");
        repeat (4) op(1, 0, 8'h20, 8'h00, 2'b01, 0);
        op(1, 0, 8'h20, 8'h13, 2'b11, 0);

        // latched A combined with a late B
        op(1, 1, 8'h09, 8'h00, 2'b01, 0);
        expectHold(1, "wait3 hold");
        expectResult(2, 10'h007, F_NONE, "latched a sub");
        op(1, 1, 8'hEE, 8'h02, 2'b10, 0);

        // reset aborts WAIT
        op(1, 0, 8'h40, 8'h01, 2'b11, 0); expectResult(1, 10'h041, F_NONE, "add pre rst");
        op(1, 0, 8'h05, 8'h00, 2'b01, 0); expectHold(1, "wait4 hold");
        op(1, 0, 8'h05, 8'h00, 2'b01, 0); expectHold(1, "wait4 hold2");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'hFF, 8'h01, 2'b11, 1'b0);
        expectResult(1, 10'h000, F_NONE, "rst in wait");
        op(1, 0, 8'h01, 8'h01, 2'b11, 0); expectResult(1, 10'h002, F_NONE, "idle after rst");

        // reset aborts multiply
        op(1, 9, 8'h03, 8'h04, 2'b11, 0); expectHold(1, "mul4 hold");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'hFF, 8'h01, 2'b11, 1'b0);
        expectResult(1, 10'h000, F_NONE, "rst in mul");
        op(1, 0, 8'h02, 8'h03, 2'b11, 0); expectResult(1, 10'h005, F_NONE, "idle after mul rst");

        idle(0);
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(negedge clk);
        while (sb_q.size() > 0) begin
            exp_t x;
            x = sb_q.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s: never compared, want res=%h flags=%b at cycle %0d",
                     x.name, x.res, x.flags, x.due);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modport_alu.md
MODPORT_ALU -- requirements
Module: modport_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand width.
REQ-002 Parameter CMD_WIDTH, default 4, command width.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 opa, opb  input  WIDTH  operands A and B.
REQ-006 cmd  input  CMD_WIDTH  operation select.
REQ-007 inp_valid  input  2  bit0 = opa valid, bit1 = opb valid.
REQ-008 ce  input  1  clock enable.
REQ-009 cin  input  1  carry-in.
REQ-010 mode  input  1  1 = arithmetic, 0 = logical.
REQ-011 res  output  WIDTH+2  result, registered.
REQ-012 err, oflow, cout, g, l, e  output  1 each  error, overflow/borrow, carry-out, A>B, A<B, A==B; all registered.

Function
REQ-013 Inputs SHALL be sampled at a posedge with ce=1 and rst=0; outputs update at the next posedge (latency 1), except multiply commands (latency 2).
REQ-014 With ce=0, all outputs and internal state SHALL hold.
REQ-015 Arithmetic (mode=1) commands:
- 0 ADD, 1 SUB, 2 ADD+cin, 3 SUB-cin.
- 4 A+1, 5 A-1, 6 B+1, 7 B-1.
- 8 CMP.
- 9 (A+1)*(B+1), 10 (A<<1)*B.
- 11 signed A+B, 12 signed A-B.
REQ-016 Logical (mode=0) commands:
- 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
- 6 ~A, 7 ~B.
- 8 A>>1, 9 A<<1, 10 B>>1, 11 B<<1.
- 12 rotate A left by B, 13 rotate A right by B.
- Logical results are zero-extended to WIDTH+2.
REQ-017 Width rules:
- Add results SHALL carry their carry bit in res[WIDTH].
- Multiply results SHALL be truncated to WIDTH+2 bits.
- Rotates SHALL use opb[$clog2(WIDTH)-1:0] as the rotate amount.
REQ-018 Flag behaviour per command:
- cout = carry-out for commands 0, 2, 4, 6.
- oflow = borrow for commands 1, 3, 5, 7.
- oflow = two's-complement overflow for commands 11 and 12.
- g/l/e = unsigned compare for CMP; signed compare for commands 11 and 12.
- All non-applicable flags SHALL be 0.
REQ-019 err SHALL be 1 and res 0 for an invalid command:
- mode=1 with cmd>12.
- mode=0 with cmd>13.
REQ-020 err SHALL be 1 and res 0 for a rotate where any opb bit above $clog2(WIDTH)-1 is set.
REQ-021 err SHALL be 1 and res 0 when inp_valid=00; no wait occurs.
REQ-022 Operand requirements:
- Commands A+1, A-1, ~A and A shifts need only opa (bit0).
- Commands B+1, B-1, ~B and B shifts need only opb (bit1).
- All other commands need both operands.
REQ-023 If a required operand is missing, the block SHALL latch the valid operand and enter WAIT with a 16-cycle counter.
REQ-024 In WAIT:
- Each enabled cycle SHALL capture any newly valid operand.
- Once all required operands are valid, compute with the latched values, then return to IDLE.
- If the operands are not complete after 16 enabled cycles, set err=1 with res=0 and return to IDLE.
REQ-025 State machine: IDLE -> WAIT on partial operands; WAIT -> IDLE on completion or timeout; IDLE -> MUL1 -> IDLE for multiply commands.
REQ-026 Each new result SHALL clear all flags not set by that operation.

Reset
REQ-027 With rst=1 at a posedge:
- res, err, oflow, cout, g, l and e SHALL all be 0.
- The FSM SHALL go to IDLE and the timeout counter SHALL clear.
- An operation in flight, including multiply and WAIT, SHALL be aborted.
REQ-028 rst SHALL take priority over ce.

Verification
REQ-029 mode=1, cmd=0, opa=8'hFF, opb=8'h01, inp_valid=11, ce=1 -> next cycle res=10'h100, cout=1, err=0.
REQ-030 mode=1, cmd=8, opa=5, opb=9 -> l=1, g=0, e=0, res=0; then opa=opb=7 -> e=1.
REQ-031 mode=1, cmd=9, opa=3, opb=4 -> res=20 two cycles after sampling; intermediate cycle outputs unchanged.
REQ-032 Arithmetic commands with inp_valid=01 (opb never valid) -> after 16 ce cycles err=1, res=0; repeat supplying inp_valid=11 at cycle 5 -> correct result, err=0.
REQ-033 mode=0, cmd=12, opa=8'b1000_0001, opb=1 -> res=8'b0000_0011; opb=8'h10 -> err=1; mode=0, cmd=14 -> err=1.
REQ-034 ce=0 for 3 cycles after a result -> all outputs stable; rst=1 during WAIT or multiply -> all outputs 0 next cycle.
